// File: rtl/mem_master_if.sv
// -----------------------------------------------------------------------------
// mem_master_if
//
// Purpose:
//   Bundles the two buses around mem_master: the CPU load/store handshake
//   and the pin-level bus to the 16-bit word RAM.
//
// Modports:
//   master : view used by mem_master itself (accepts CPU requests, drives the
//            RAM pins, returns responses)
//   slave  : view used by the surrounding system (the CPU datapath drives
//            requests and consumes responses, the RAM returns read data)
//
// Signal summary:
//   req_valid/req_ready/req_rw/req_addr/req_wdata   CPU request channel
//   resp_valid/resp_ready/resp_rdata/resp_err       CPU response channel
//   mem_en/mem_rw/mem_addr/mem_wdata/mem_q          RAM control and data
//   rw polarity everywhere: 1 = read, 0 = write.
// -----------------------------------------------------------------------------
interface mem_master_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16
);

    // CPU request channel
    logic              req_valid;
    logic              req_ready;
    logic              req_rw;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;

    // CPU response channel
    logic              resp_valid;
    logic              resp_ready;
    logic [DATA_W-1:0] resp_rdata;
    logic              resp_err;

    // RAM pins
    logic              mem_en;
    logic              mem_rw;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_q;

    modport master (
        input  req_valid,
        input  req_rw,
        input  req_addr,
        input  req_wdata,
        output req_ready,
        output resp_valid,
        input  resp_ready,
        output resp_rdata,
        output resp_err,
        output mem_en,
        output mem_rw,
        output mem_addr,
        output mem_wdata,
        input  mem_q
    );

    modport slave (
        output req_valid,
        output req_rw,
        output req_addr,
        output req_wdata,
        input  req_ready,
        input  resp_valid,
        output resp_ready,
        input  resp_rdata,
        input  resp_err,
        input  mem_en,
        input  mem_rw,
        input  mem_addr,
        input  mem_wdata,
        output mem_q
    );

endinterface : mem_master_if

// File: rtl/mem_master.sv
// -----------------------------------------------------------------------------
// mem_master
//
// Purpose:
//   Processor-side initiator for the 16-bit word RAM. Takes one load/store
//   at a time from the CPU, pulses the RAM enable for a single cycle, waits
//   the RAM read latency for loads, and hands a response back to the CPU.
//   Addresses at or beyond MEM_WORDS are answered with resp_err and never
//   reach the RAM pins.
//
// Ports:
//   clk  : system clock, everything on the rising edge
//   rst  : synchronous, active-high reset; abandons any transaction in flight
//   bus  : mem_master_if.master
//            req_*  : CPU request (valid/ready). req_ready is the only
//                     combinational output: high in IDLE when not in reset.
//            resp_* : CPU response (valid/ready), held until consumed.
//                     resp_rdata is 0 for writes and errors.
//            mem_*  : RAM enable/direction/address/write data, all
//                     registered; mem_q is the RAM read data.
//
// Parameters:
//   DATA_W     : data word width (must match the interface)
//   ADDR_W     : address width (must match the interface)
//   MEM_WORDS  : number of implemented RAM words
//   RD_LATENCY : edges from the read strobe edge to valid RAM data, 1..15
//
// Timing, with the request accepted at edge T:
//   error response visible after T, write response after T+1,
//   read response after T+1+RD_LATENCY. Consuming a response returns to
//   IDLE; a new request can be taken on the following edge at the earliest.
// -----------------------------------------------------------------------------
module mem_master #(
    parameter int DATA_W     = 16,
    parameter int ADDR_W     = 16,
    parameter int MEM_WORDS  = 512,
    parameter int RD_LATENCY = 1
) (
    input  logic         clk,
    input  logic         rst,
    mem_master_if.master bus
);

    // Four bits cover the full 1..15 latency range.
    localparam int CNT_W = 4;

    // One extra bit on the limit keeps the range test exact even when
    // MEM_WORDS equals 2**ADDR_W; addresses are compared, never truncated.
    localparam logic [ADDR_W:0]  MEM_LIMIT  = (ADDR_W + 1)'(MEM_WORDS);
    localparam logic [CNT_W-1:0] RD_LAT_CNT = CNT_W'(RD_LATENCY);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE,   // waiting for a CPU request
        ST_ISSUE,  // RAM strobe cycle, mem_en high
        ST_WAIT,   // counting down the RAM read latency
        ST_RESP    // response presented, waiting for resp_ready
    } state_e;

    state_e            state_d,      state_q;
    logic              mem_en_d,     mem_en_q;
    logic              mem_rw_d,     mem_rw_q;
    logic [ADDR_W-1:0] mem_addr_d,   mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_d,  mem_wdata_q;
    logic              resp_valid_d, resp_valid_q;
    logic [DATA_W-1:0] resp_rdata_d, resp_rdata_q;
    logic              resp_err_d,   resp_err_q;
    logic [CNT_W-1:0]  cnt_d,        cnt_q;

    logic accept;
    logic addr_err;

    // Gating with rst makes a request that coincides with reset invisible:
    // reset always wins over acceptance.
    assign bus.req_ready = (state_q == ST_IDLE) && !rst;
    assign accept        = bus.req_valid && bus.req_ready;
    assign addr_err      = {1'b0, bus.req_addr} >= MEM_LIMIT;

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every variable assigned here gets a hold-value default first,
        // so no path through the case leaves one unassigned (no latches).
        state_d      = state_q;
        mem_en_d     = mem_en_q;
        mem_rw_d     = mem_rw_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        resp_valid_d = resp_valid_q;
        resp_rdata_d = resp_rdata_q;
        resp_err_d   = resp_err_q;
        cnt_d        = cnt_q;

        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (addr_err) begin
                        // Out-of-range: answer immediately, RAM pins untouched.
                        state_d      = ST_RESP;
                        resp_valid_d = 1'b1;
                        resp_err_d   = 1'b1;
                        resp_rdata_d = '0;
                    end else begin
                        state_d     = ST_ISSUE;
                        mem_en_d    = 1'b1;
                        mem_rw_d    = bus.req_rw;
                        mem_addr_d  = bus.req_addr;
                        mem_wdata_d = bus.req_wdata;
                    end
                end
            end

            ST_ISSUE: begin
                // Strobe ends here; parking rw at read means a stray enable
                // could never turn into a write.
                mem_en_d = 1'b0;
                mem_rw_d = 1'b1;
                if (mem_rw_q) begin
                    state_d = ST_WAIT;
                    cnt_d   = RD_LAT_CNT;
                end else begin
                    state_d      = ST_RESP;
                    resp_valid_d = 1'b1;
                    resp_err_d   = 1'b0;
                    resp_rdata_d = '0;
                end
            end

            ST_WAIT: begin
                cnt_d = cnt_q - CNT_ONE;
                // mem_q is only trusted on this edge; before it the RAM output
                // may still be showing an older word.
                if (cnt_q == CNT_ONE) begin
                    state_d      = ST_RESP;
                    resp_valid_d = 1'b1;
                    resp_err_d   = 1'b0;
                    resp_rdata_d = bus.mem_q;
                end
            end

            ST_RESP: begin
                if (resp_valid_q && bus.resp_ready) begin
                    state_d      = ST_IDLE;
                    resp_valid_d = 1'b0;
                    resp_err_d   = 1'b0;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments here so every flop samples the values
        // from before the edge, independent of statement order.
        if (rst) begin
            state_q      <= ST_IDLE;
            mem_en_q     <= 1'b0;
            mem_rw_q     <= 1'b1;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            mem_en_q     <= mem_en_d;
            mem_rw_q     <= mem_rw_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
            cnt_q        <= cnt_d;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign bus.mem_en     = mem_en_q;
    assign bus.mem_rw     = mem_rw_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_wdata  = mem_wdata_q;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_rdata = resp_rdata_q;
    assign bus.resp_err   = resp_err_q;

endmodule : mem_master

// File: tb/tb_mem_master.sv
// -----------------------------------------------------------------------------
// tb_mem_master
//
// Two instances share clock, reset and request fields: dut_a with
// RD_LATENCY=1 and dut_b with RD_LATENCY=3. Each has its own RAM model
// that drives random garbage on Q whenever no read data is due. Expected
// results come from a word-array reference model and the timing rules
// (error after 0 edges, write after 1, read after 1+latency).
// -----------------------------------------------------------------------------
module tb_mem_master;

    localparam int DATA_W    = 16;
    localparam int ADDR_W    = 16;
    localparam int MEM_WORDS = 512;
    localparam int LAT_A     = 1;
    localparam int LAT_B     = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mem_master_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus_a ();
    mem_master_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus_b ();

    mem_master #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .MEM_WORDS(MEM_WORDS), .RD_LATENCY(LAT_A)
    ) dut_a (
        .clk(clk),
        .rst(rst),
        .bus(bus_a.master)
    );

    mem_master #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .MEM_WORDS(MEM_WORDS), .RD_LATENCY(LAT_B)
    ) dut_b (
        .clk(clk),
        .rst(rst),
        .bus(bus_b.master)
    );

    // Shared request fields, per-instance valid.
    logic        t_rw      = 1'b1;
    logic [15:0] t_addr    = '0;
    logic [15:0] t_wdata   = '0;
    logic        t_rdy     = 1'b0;
    logic        t_valid_a = 1'b0;
    logic        t_valid_b = 1'b0;

    assign bus_a.req_valid  = t_valid_a;
    assign bus_a.req_rw     = t_rw;
    assign bus_a.req_addr   = t_addr;
    assign bus_a.req_wdata  = t_wdata;
    assign bus_a.resp_ready = t_rdy;
    assign bus_b.req_valid  = t_valid_b;
    assign bus_b.req_rw     = t_rw;
    assign bus_b.req_addr   = t_addr;
    assign bus_b.req_wdata  = t_wdata;
    assign bus_b.resp_ready = t_rdy;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // ------------------------------------------------------------------
    // RAM models and pin monitors
    // ------------------------------------------------------------------
    logic [15:0] ram_a [0:MEM_WORDS-1] = '{default: 16'h0000};
    logic [15:0] ram_b [0:MEM_WORDS-1] = '{default: 16'h0000};
    logic [15:0] q_a = '0;
    logic [15:0] q_b = '0;
    logic [1:0]        rv_b = '0;
    logic [1:0][15:0]  rd_b = '0;
    int en_cnt_a = 0, wr_cnt_a = 0, oob_a = 0;
    int en_cnt_b = 0, wr_cnt_b = 0, oob_b = 0;

    // Latency 1: data for a strobe at edge E appears right after E.
    always @(posedge clk) begin
        if (bus_a.mem_en) en_cnt_a <= en_cnt_a + 1;
        if (bus_a.mem_en && !bus_a.mem_rw) wr_cnt_a <= wr_cnt_a + 1;
        if (bus_a.mem_en && int'(bus_a.mem_addr) >= MEM_WORDS) oob_a <= oob_a + 1;
        if (bus_a.mem_en && !bus_a.mem_rw && int'(bus_a.mem_addr) < MEM_WORDS)
            ram_a[bus_a.mem_addr[8:0]] <= bus_a.mem_wdata;
        if (bus_a.mem_en && bus_a.mem_rw && int'(bus_a.mem_addr) < MEM_WORDS)
            q_a <= ram_a[bus_a.mem_addr[8:0]];
        else
            q_a <= 16'($urandom);
    end
    assign bus_a.mem_q = q_a;

    // Latency 3: data for a strobe at edge E appears only after E+2.
    always @(posedge clk) begin
        if (bus_b.mem_en) en_cnt_b <= en_cnt_b + 1;
        if (bus_b.mem_en && !bus_b.mem_rw) wr_cnt_b <= wr_cnt_b + 1;
        if (bus_b.mem_en && int'(bus_b.mem_addr) >= MEM_WORDS) oob_b <= oob_b + 1;
        if (bus_b.mem_en && !bus_b.mem_rw && int'(bus_b.mem_addr) < MEM_WORDS)
            ram_b[bus_b.mem_addr[8:0]] <= bus_b.mem_wdata;
        rv_b[0] <= bus_b.mem_en && bus_b.mem_rw && int'(bus_b.mem_addr) < MEM_WORDS;
        rd_b[0] <= ram_b[bus_b.mem_addr[8:0]];
        rv_b[1] <= rv_b[0];
        rd_b[1] <= rd_b[0];
        q_b     <= rv_b[1] ? rd_b[1] : 16'($urandom);
    end
    assign bus_b.mem_q = q_b;

    // ------------------------------------------------------------------
    // Reference model: plain word arrays plus the timing rules
    // ------------------------------------------------------------------
    logic [15:0] exp_a [0:MEM_WORDS-1];
    logic [15:0] exp_b [0:MEM_WORDS-1];

    task automatic model_txn(input bit sel, input bit rw, input logic [15:0] addr,
                             input logic [15:0] wdata, output logic [15:0] e_rdata,
                             output logic e_err, output int e_lat);
        int lat;
        lat     = sel ? LAT_B : LAT_A;
        e_err   = (int'(addr) >= MEM_WORDS);
        e_rdata = '0;
        if (e_err) begin
            e_lat = 0;
        end else if (rw) begin
            e_lat   = 1 + lat;
            e_rdata = sel ? exp_b[int'(addr)] : exp_a[int'(addr)];
        end else begin
            e_lat = 1;
            if (sel) exp_b[int'(addr)] = wdata;
            else     exp_a[int'(addr)] = wdata;
        end
    endtask

    // Drives one request on the chosen instance and collects what came back.
    // Latency is the number of edges after the acceptance edge before
    // resp_valid is seen.
    task automatic do_txn(input bit sel, input bit rw, input logic [15:0] addr,
                          input logic [15:0] wdata, output logic [15:0] g_rdata,
                          output logic g_err, output int g_lat, output int g_en,
                          output int g_wr, output bit g_to);
        int en0, wr0, n;
        g_to    = 1'b0;
        g_rdata = '0;
        g_err   = 1'b0;
        g_lat   = 0;
        en0     = sel ? en_cnt_b : en_cnt_a;
        wr0     = sel ? wr_cnt_b : wr_cnt_a;
        @(negedge clk);
        t_rw    = rw;
        t_addr  = addr;
        t_wdata = wdata;
        if (sel) t_valid_b = 1'b1;
        else     t_valid_a = 1'b1;
        n = 0;
        while (!(sel ? bus_b.req_ready : bus_a.req_ready) && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) g_to = 1'b1;
        @(negedge clk);
        t_valid_a = 1'b0;
        t_valid_b = 1'b0;
        while (!(sel ? bus_b.resp_valid : bus_a.resp_valid) && g_lat < 40) begin
            @(negedge clk);
            g_lat++;
        end
        if (g_lat >= 40) g_to = 1'b1;
        g_rdata = sel ? bus_b.resp_rdata : bus_a.resp_rdata;
        g_err   = sel ? bus_b.resp_err   : bus_a.resp_err;
        t_rdy   = 1'b1;
        @(negedge clk);
        t_rdy   = 1'b0;
        g_en    = (sel ? en_cnt_b : en_cnt_a) - en0;
        g_wr    = (sel ? wr_cnt_b : wr_cnt_a) - wr0;
    endtask

    task automatic run_and_score(input bit sel, input bit rw, input logic [15:0] addr,
                                 input logic [15:0] wdata, input string tag);
        logic [15:0] e_rdata, g_rdata;
        logic        e_err, g_err;
        int          e_lat, g_lat, g_en, g_wr;
        bit          g_to;
        model_txn(sel, rw, addr, wdata, e_rdata, e_err, e_lat);
        do_txn(sel, rw, addr, wdata, g_rdata, g_err, g_lat, g_en, g_wr, g_to);
        checks++;
        if (g_to) begin
            errors++;
            $display("FAIL %s timeout: no handshake within budget, want completion", tag);
        end
        checks++;
        if (g_err !== e_err) begin
            errors++;
            $display("FAIL %s resp_err: got %0b want %0b", tag, g_err, e_err);
        end
        checks++;
        if (g_rdata !== e_rdata) begin
            errors++;
            $display("FAIL %s resp_rdata: got %h want %h", tag, g_rdata, e_rdata);
        end
        checks++;
        if (g_lat !== e_lat) begin
            errors++;
            $display("FAIL %s latency: got %0d want %0d", tag, g_lat, e_lat);
        end
        checks++;
        if (g_en !== (e_err ? 0 : 1)) begin
            errors++;
            $display("FAIL %s mem_en_cycles: got %0d want %0d", tag, g_en, e_err ? 0 : 1);
        end
        checks++;
        if (g_wr !== ((!e_err && !rw) ? 1 : 0)) begin
            errors++;
            $display("FAIL %s write_strobes: got %0d want %0d", tag, g_wr,
                     (!e_err && !rw) ? 1 : 0);
        end
    endtask

    task automatic compare_ram(input bit sel, input string tag);
        int bad;
        bad = 0;
        for (int i = 0; i < MEM_WORDS; i++) begin
            if (sel ? (ram_b[i] !== exp_b[i]) : (ram_a[i] !== exp_a[i])) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL %s: %0d RAM words differ from model, want 0", tag, bad);
        end
        checks++;
        if ((sel ? oob_b : oob_a) != 0) begin
            errors++;
            $display("FAIL %s oob_strobes: got %0d want 0", tag, sel ? oob_b : oob_a);
        end
    endtask

    // ------------------------------------------------------------------
    // Scenarios
    // ------------------------------------------------------------------
    task automatic test_reset();
        // Request held valid during reset must not be taken.
        rst       = 1'b1;
        t_valid_a = 1'b1;
        t_valid_b = 1'b1;
        t_rw      = 1'b0;
        t_addr    = 16'h0005;
        t_wdata   = 16'h1234;
        repeat (2) begin
            @(negedge clk);
            checks++;
            if (bus_a.req_ready !== 1'b0 || bus_b.req_ready !== 1'b0) begin
                errors++;
                $display("FAIL reset_req_ready: got %b/%b want 0/0",
                         bus_a.req_ready, bus_b.req_ready);
            end
            checks++;
            if (bus_a.mem_en !== 1'b0 || bus_b.mem_en !== 1'b0) begin
                errors++;
                $display("FAIL reset_mem_en: got %b/%b want 0/0", bus_a.mem_en, bus_b.mem_en);
            end
        end
        rst       = 1'b0;
        t_valid_a = 1'b0;
        t_valid_b = 1'b0;
        @(negedge clk);
        checks++;
        if (bus_a.req_ready !== 1'b1 || bus_b.req_ready !== 1'b1) begin
            errors++;
            $display("FAIL post_reset_req_ready: got %b/%b want 1/1",
                     bus_a.req_ready, bus_b.req_ready);
        end
        checks++;
        if ({bus_a.mem_en, bus_a.mem_rw, bus_a.resp_valid, bus_a.resp_err} !== 4'b0100) begin
            errors++;
            $display("FAIL post_reset_ctrl en/rw/valid/err: got %b want 0100",
                     {bus_a.mem_en, bus_a.mem_rw, bus_a.resp_valid, bus_a.resp_err});
        end
        checks++;
        if (bus_a.mem_addr !== 16'h0 || bus_a.mem_wdata !== 16'h0 || bus_a.resp_rdata !== 16'h0) begin
            errors++;
            $display("FAIL post_reset_data addr/wdata/rdata: got %h/%h/%h want 0/0/0",
                     bus_a.mem_addr, bus_a.mem_wdata, bus_a.resp_rdata);
        end
        checks++;
        if (wr_cnt_a != 0 || wr_cnt_b != 0) begin
            errors++;
            $display("FAIL reset_no_write: got %0d/%0d write strobes want 0/0", wr_cnt_a, wr_cnt_b);
        end
    endtask

    task automatic test_write_read();
        run_and_score(1'b0, 1'b0, 16'h0005, 16'hBEEF, "wr_0005");
        run_and_score(1'b0, 1'b1, 16'h0005, 16'h0000, "rd_0005");
    endtask

    task automatic test_boundary();
        run_and_score(1'b0, 1'b0, 16'h01FF, 16'($urandom), "wr_01ff");
        run_and_score(1'b0, 1'b1, 16'h01FF, 16'h0000, "rd_01ff");
        run_and_score(1'b0, 1'b1, 16'h0200, 16'h0000, "rd_0200_err");
        run_and_score(1'b0, 1'b0, 16'h0200, 16'hFFFF, "wr_0200_err");
        run_and_score(1'b0, 1'b0, 16'h8000, 16'hA5A5, "wr_8000_err");
        run_and_score(1'b0, 1'b1, 16'hFFFF, 16'h0000, "rd_ffff_err");
        run_and_score(1'b0, 1'b1, 16'h0000, 16'h0000, "rd_0000_after_err");
        compare_ram(1'b0, "boundary_ram");
    endtask

    task automatic test_backpressure();
        logic [15:0] e_rdata;
        logic        e_err;
        int          e_lat, n;
        run_and_score(1'b0, 1'b0, 16'h0010, 16'($urandom), "wr_0010");
        model_txn(1'b0, 1'b1, 16'h0010, 16'h0000, e_rdata, e_err, e_lat);
        @(negedge clk);
        t_rw      = 1'b1;
        t_addr    = 16'h0010;
        t_valid_a = 1'b1;
        n = 0;
        while (!bus_a.req_ready && n < 20) begin @(negedge clk); n++; end
        @(negedge clk);
        t_valid_a = 1'b0;
        n = 0;
        while (!bus_a.resp_valid && n < 20) begin @(negedge clk); n++; end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (bus_a.resp_valid !== 1'b1 || bus_a.resp_rdata !== e_rdata) begin
                errors++;
                $display("FAIL bp_hold cycle %0d: valid %b rdata %h, want valid 1 rdata %h",
                         i, bus_a.resp_valid, bus_a.resp_rdata, e_rdata);
            end
            checks++;
            if (bus_a.req_ready !== 1'b0) begin
                errors++;
                $display("FAIL bp_req_ready cycle %0d: got %b want 0", i, bus_a.req_ready);
            end
            @(negedge clk);
        end
        t_rdy = 1'b1;
        checks++;
        if (bus_a.req_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_consume_cycle_ready: got %b want 0", bus_a.req_ready);
        end
        @(negedge clk);
        t_rdy = 1'b0;
        checks++;
        if (bus_a.resp_valid !== 1'b0 || bus_a.req_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_after_consume valid/ready: got %b/%b want 0/1",
                     bus_a.resp_valid, bus_a.req_ready);
        end
    endtask

    task automatic test_back_to_back();
        int          acc [8];
        int          n;
        logic [15:0] e_rdata;
        logic        e_err;
        int          e_lat;
        @(negedge clk);
        t_rdy = 1'b1;
        for (int k = 0; k < 8; k++) begin
            // Four writes to 0x20..0x23, then four reads of the same words.
            t_rw    = (k >= 4);
            t_addr  = 16'(16'h0020 + (k % 4));
            t_wdata = 16'($urandom);
            model_txn(1'b0, t_rw, t_addr, t_wdata, e_rdata, e_err, e_lat);
            t_valid_a = 1'b1;
            n = 0;
            while (!bus_a.req_ready && n < 20) begin @(negedge clk); n++; end
            acc[k] = cyc;
            @(negedge clk);
        end
        t_valid_a = 1'b0;
        repeat (8) @(negedge clk);
        t_rdy = 1'b0;
        for (int k = 1; k < 8; k++) begin
            if (k == 4) continue;
            checks++;
            if (acc[k] - acc[k-1] != ((k < 4) ? 3 : 3 + LAT_A)) begin
                errors++;
                $display("FAIL b2b_interval %0d: got %0d cycles want %0d",
                         k, acc[k] - acc[k-1], (k < 4) ? 3 : 3 + LAT_A);
            end
        end
    endtask

    task automatic test_random();
        int          pick;
        logic [15:0] addr;
        for (int i = 0; i < 40; i++) begin
            pick = $urandom_range(0, 9);
            if (pick < 6)       addr = 16'($urandom_range(0, 15));
            else if (pick == 6) addr = 16'h01FF;
            else if (pick == 7) addr = 16'h0200;
            else                addr = 16'($urandom_range(MEM_WORDS, 65535));
            run_and_score(1'b0, 1'($urandom_range(0, 1)), addr, 16'($urandom),
                          $sformatf("rand_%0d", i));
        end
        compare_ram(1'b0, "random_ram");
    endtask

    task automatic test_latency3();
        run_and_score(1'b1, 1'b0, 16'h0005, 16'hBEEF, "l3_wr_0005");
        run_and_score(1'b1, 1'b1, 16'h0005, 16'h0000, "l3_rd_0005");
        run_and_score(1'b1, 1'b1, 16'h0200, 16'h0000, "l3_rd_0200_err");
        for (int i = 0; i < 16; i++) begin
            run_and_score(1'b1, 1'($urandom_range(0, 1)), 16'($urandom_range(0, 7)),
                          16'($urandom), $sformatf("l3_rand_%0d", i));
        end
        compare_ram(1'b1, "l3_ram");
    endtask

    task automatic test_reset_mid_read();
        int n, seen;
        run_and_score(1'b0, 1'b0, 16'h0033, 16'h5A3C, "mid_wr_0033");
        @(negedge clk);
        t_rw      = 1'b1;
        t_addr    = 16'h0033;
        t_valid_a = 1'b1;
        n = 0;
        while (!bus_a.req_ready && n < 20) begin @(negedge clk); n++; end
        @(negedge clk);               // after acceptance edge: strobe cycle
        t_valid_a = 1'b0;
        @(negedge clk);               // after strobe: waiting for read data
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (bus_a.resp_valid !== 1'b0 || bus_a.mem_en !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_outputs valid/en: got %b/%b want 0/0",
                     bus_a.resp_valid, bus_a.mem_en);
        end
        @(negedge clk);
        rst  = 1'b0;
        seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (bus_a.resp_valid !== 1'b0) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL mid_reset_no_response: resp_valid seen %0d cycles want 0", seen);
        end
        run_and_score(1'b0, 1'b1, 16'h0033, 16'h0000, "mid_rd_0033");
    endtask

    // ------------------------------------------------------------------
    // Sequence
    // ------------------------------------------------------------------
    initial begin
        for (int i = 0; i < MEM_WORDS; i++) begin
            exp_a[i] = 16'h0000;
            exp_b[i] = 16'h0000;
        end
        test_reset();
        test_write_read();
        test_boundary();
        test_backpressure();
        test_back_to_back();
        test_random();
        test_latency3();
        test_reset_mid_read();
        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_mem_master
